// File: rtl/reg_op_arbiter.sv
// reg_op_arbiter
// Arbitrates two requesters that share one load/hold/clear/complement register
// datapath. The register itself lives outside; this block drives its 4:1 select
// lines (SEL) and load data (DOUT), and stretches complement operations into
// multi-cycle bursts.
//
// Operation / SEL encoding: 00 hold, 01 load DOUT, 10 clear, 11 complement.
//
// Ports:
//   CLK                 clock, rising edge
//   RST_n               synchronous active-low reset
//   REQ0/OP0/DATA0/RPT0 requester 0 request (level), op, load data, repeat count
//   REQ1/OP1/DATA1/RPT1 requester 1, same fields
//   GNT[1:0]            one-hot grant pulse (first EXEC cycle)
//   DONE[1:0]           one-hot completion pulse (DONE cycle)
//   SEL[1:0]            datapath select
//   DOUT[WIDTH-1:0]     datapath load data (last latched value)
//   BUSY                high while executing or completing an operation
//   OWNER               current or last-served requester
//
// Build option: define REG_OP_ARBITER_FIXED_PRIO_EN to make requester 0 win
// every tie instead of round-robin arbitration.
module reg_op_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             REQ0,
  input  logic [1:0]       OP0,
  input  logic [WIDTH-1:0] DATA0,
  input  logic [CNTW-1:0]  RPT0,
  input  logic             REQ1,
  input  logic [1:0]       OP1,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [CNTW-1:0]  RPT1,
  output logic [1:0]       GNT,
  output logic [1:0]       DONE,
  output logic [1:0]       SEL,
  output logic [WIDTH-1:0] DOUT,
  output logic             BUSY,
  output logic             OWNER
);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam logic [1:0] OP_COMPL = 2'b11;

  arb_state_t       state_reg, state_next;
  logic             owner_reg, owner_next;
  logic             last_reg, last_next;
  logic             first_reg, first_next;
  logic [1:0]       op_reg, op_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [CNTW-1:0]  cnt_reg, cnt_next;

  logic             winner;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_data;
  logic [CNTW-1:0]  win_rpt;

  // Winner selection; only consulted in ARB_IDLE when at least one REQ is high.
  always_comb begin
    winner = 1'b0;
`ifdef REG_OP_ARBITER_FIXED_PRIO_EN
    winner = ~REQ0;
`else
    case ({REQ1, REQ0})
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = ~last_reg;  // tie: whoever was not served last
    endcase
`endif
    win_op   = winner ? OP1   : OP0;
    win_data = winner ? DATA1 : DATA0;
    win_rpt  = winner ? RPT1  : RPT0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_reg <= ARB_IDLE;
      owner_reg <= 1'b1;
      last_reg  <= 1'b1;  // makes requester 0 win the first tie
      first_reg <= 1'b0;
      op_reg    <= 2'b00;
      data_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      first_reg <= first_next;
      op_reg    <= op_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    first_next = 1'b0;
    op_next    = op_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (REQ0 || REQ1) begin
          owner_next = winner;
          op_next    = win_op;
          data_next  = win_data;
          // Only complements repeat; every other op executes exactly once.
          cnt_next   = (win_op == OP_COMPL) ? win_rpt : '0;
          first_next = 1'b1;
          state_next = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        if (cnt_reg == '0) begin
          state_next = ARB_DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ARB_DONE: begin
        last_next  = owner_reg;
        state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Outputs decode purely from registered state and latched fields.
  assign SEL   = (state_reg == ARB_EXEC) ? op_reg : 2'b00;
  assign DOUT  = data_reg;
  assign BUSY  = (state_reg == ARB_EXEC) || (state_reg == ARB_DONE);
  assign OWNER = owner_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_handshake
    assign GNT[gi]  = (state_reg == ARB_EXEC) && first_reg && (owner_reg == gi[0]);
    assign DONE[gi] = (state_reg == ARB_DONE) && (owner_reg == gi[0]);
  end

endmodule

// File: tb/tb_reg_op_arbiter.sv
// Bench for reg_op_arbiter: a behavioural model of the external register plus
// a scoreboard of expected grants/completions, checked by an independent monitor.
module tb_reg_op_arbiter;
  localparam int WIDTH = 8;
  localparam int CNTW  = 4;

  logic             CLK = 1'b0;
  logic             RST_n = 1'b0;
  logic             REQ0 = 1'b0, REQ1 = 1'b0;
  logic [1:0]       OP0 = 2'b00, OP1 = 2'b00;
  logic [WIDTH-1:0] DATA0 = '0, DATA1 = '0;
  logic [CNTW-1:0]  RPT0 = '0, RPT1 = '0;
  logic [1:0]       GNT, DONE, SEL;
  logic [WIDTH-1:0] DOUT;
  logic             BUSY, OWNER;

  reg_op_arbiter #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .REQ0(REQ0), .OP0(OP0), .DATA0(DATA0), .RPT0(RPT0),
    .REQ1(REQ1), .OP1(OP1), .DATA1(DATA1), .RPT1(RPT1),
    .GNT(GNT), .DONE(DONE), .SEL(SEL), .DOUT(DOUT), .BUSY(BUSY), .OWNER(OWNER)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]       gnt;
    logic             owner;
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    int               len;
    logic [WIDTH-1:0] exp_q;
  } exp_t;

  exp_t             sb_q[$];
  int               checks = 0, errors = 0;
  int               gnt_count = 0, done_count = 0;
  logic [WIDTH-1:0] plant_q = '0;   // the external register
  logic [WIDTH-1:0] model_q = '0;   // reference value of that register
  bit               last_served = 1'b1;
  bit               rst_seen = 1'b0;

  always @(posedge CLK) begin
    case (SEL)
      2'b01:   plant_q <= DOUT;
      2'b10:   plant_q <= '0;
      2'b11:   plant_q <= ~plant_q;
      default: plant_q <= plant_q;
    endcase
  end

  always @(posedge CLK) if (!RST_n) rst_seen = 1'b1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops an expectation on each grant, follows the operation to DONE.
  bit   tracking = 1'b0;
  int   len = 0;
  exp_t cur;
  always @(negedge CLK) begin
    if (rst_seen) begin
      tracking = 1'b0;
      rst_seen = 1'b0;
    end
    if (GNT != 2'b00) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_gnt", int'(GNT), 0);
      end else begin
        cur = sb_q.pop_front();
        chk("gnt", int'(GNT), int'(cur.gnt));
        chk("sel_first", int'(SEL), int'(cur.op));
        chk("dout", int'(DOUT), int'(cur.data));
        chk("owner", int'(OWNER), int'(cur.owner));
        chk("busy_exec", int'(BUSY), 1);
        $display("grant  req%0d op=%0d data=%02h len=%0d", cur.owner, cur.op, cur.data, cur.len);
        tracking = 1'b1;
        len = 1;
        gnt_count++;
      end
    end else if (DONE != 2'b00) begin
      if (!tracking) begin
        chk("spurious_done", int'(DONE), 0);
      end else begin
        chk("done", int'(DONE), cur.owner ? 2 : 1);
        chk("exec_len", len, cur.len);
        chk("reg_value", int'(plant_q), int'(cur.exp_q));
        chk("sel_done", int'(SEL), 0);
        chk("busy_done", int'(BUSY), 1);
        $display("done   req%0d reg=%02h", cur.owner, plant_q);
        tracking = 1'b0;
        done_count++;
      end
    end else if (tracking) begin
      chk("sel_exec", int'(SEL), int'(cur.op));
      len++;
    end
  end

  // Reference model: decides the winner and the register result per request.
  task automatic issue(input bit r0, input bit r1,
                       input logic [1:0] o0, input logic [WIDTH-1:0] d0, input logic [CNTW-1:0] p0,
                       input logic [1:0] o1, input logic [WIDTH-1:0] d1, input logic [CNTW-1:0] p1);
    bit   w;
    exp_t e;
    int   rpt;
    if (r0 && r1) begin
`ifdef REG_OP_ARBITER_FIXED_PRIO_EN
      w = 1'b0;
`else
      w = !last_served;
`endif
    end else begin
      w = r1;
    end
    e.owner = w;
    e.gnt   = w ? 2'b10 : 2'b01;
    e.op    = w ? o1 : o0;
    e.data  = w ? d1 : d0;
    rpt     = w ? int'(p1) : int'(p0);
    e.len   = (e.op == 2'b11) ? rpt + 1 : 1;
    case (e.op)
      2'b01:   model_q = e.data;
      2'b10:   model_q = '0;
      2'b11:   if ((e.len % 2) == 1) model_q = ~model_q;
      default: ;
    endcase
    e.exp_q = model_q;
    last_served = w;
    sb_q.push_back(e);
    REQ0 = r0; OP0 = o0; DATA0 = d0; RPT0 = p0;
    REQ1 = r1; OP1 = o1; DATA1 = d1; RPT1 = p1;
  endtask

  task automatic wait_done(input int n);
    int start = done_count;
    int c = 0;
    while (done_count < start + n && c < 40 * n) begin
      @(negedge CLK); #1;
      c++;
    end
    if (done_count < start + n) begin
      chk("done_timeout", done_count - start, n);
      sb_q.delete();
    end
  endtask

  task automatic wait_gnt();
    int start = gnt_count;
    int c = 0;
    while (gnt_count == start && c < 20) begin
      @(negedge CLK); #1;
      c++;
    end
    if (gnt_count == start) chk("gnt_timeout", 0, 1);
  endtask

  task automatic drop();
    REQ0 = 1'b0;
    REQ1 = 1'b0;
  endtask

  initial begin
    int start_done;
    repeat (3) @(negedge CLK);
    chk("rst_gnt", int'(GNT), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_sel", int'(SEL), 0);
    chk("rst_dout", int'(DOUT), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_owner", int'(OWNER), 1);
    #1 RST_n = 1'b1;
    plant_q = '0;
    model_q = '0;
    @(negedge CLK); #1;

    // Directed: load A5, complement x3, hold, load with mid-op field change.
    issue(1, 0, 2'b01, 8'hA5, 4'd0, 2'b00, 8'h00, 4'd0);
    wait_done(1); drop();
    issue(0, 1, 2'b00, 8'h00, 4'd0, 2'b11, 8'h00, 4'd2);
    wait_done(1); drop();
    chk("owner_after_req1", int'(OWNER), 1);
    issue(1, 0, 2'b00, 8'h11, 4'd0, 2'b00, 8'h00, 4'd0);
    wait_done(1); drop();
    issue(1, 0, 2'b01, 8'h3C, 4'd0, 2'b00, 8'h00, 4'd0);
    wait_gnt();
    DATA0 = 8'hFF; REQ0 = 1'b0;
    wait_done(1);

    // Both held high: grants alternate (or stay on req0 with fixed priority).
    for (int i = 0; i < 4; i++) issue(1, 1, 2'b10, 8'h00, 4'd0, 2'b10, 8'h00, 4'd0);
    wait_done(4); drop();

    // Reset during the 4th cycle of a 16-long complement burst.
    issue(1, 0, 2'b11, 8'h00, 4'd15, 2'b00, 8'h00, 4'd0);
    wait_gnt();
    repeat (3) begin @(negedge CLK); #1; end
    RST_n = 1'b0; drop();
    start_done = done_count;
    last_served = 1'b1;  // four complements: register value back where it was
    @(negedge CLK); #1;
    chk("abort_sel", int'(SEL), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(DONE), 0);
    chk("abort_owner", int'(OWNER), 1);
    chk("abort_reg", int'(plant_q), int'(model_q));
    RST_n = 1'b1;
    repeat (3) begin @(negedge CLK); #1; end
    chk("abort_no_done", done_count, start_done);
    issue(1, 1, 2'b01, 8'h5E, 4'd0, 2'b01, 8'hE5, 4'd0);
    wait_done(1); drop();

    // Randomized rounds.
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(1, 3);
      issue(r[0], r[1],
            2'($urandom), 8'($urandom), 4'($urandom),
            2'($urandom), 8'($urandom), 4'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        wait_gnt();
        OP0 = 2'($urandom); DATA0 = 8'($urandom); RPT0 = 4'($urandom);
        OP1 = 2'($urandom); DATA1 = 8'($urandom); RPT1 = 4'($urandom);
        drop();
        wait_done(1);
      end else begin
        wait_done(1);
        drop();
      end
    end
    repeat (3) @(negedge CLK);
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
